// File: rtl/output_hex_uart.sv
// Buffers cluster output words in a FIFO and sends each as four lowercase hex digits plus LF over 8N1 UART.
// Optional OUTPUT_HEX_UART_OVERFLOW_COUNT_EN adds a saturating dropped-word counter and a '!' marker before LF.
module output_hex_uart #(
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        output_enable,
    input  logic [15:0] output_data_val,
    output logic        uart_tx,
    output logic        fifo_full,
    output logic        busy
`ifdef OUTPUT_HEX_UART_OVERFLOW_COUNT_EN
    ,
    output logic [7:0]  overflow_count
`endif
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state;
    logic [15:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [15:0]    hold;
    logic [2:0]     char_idx;
    logic [2:0]     bit_idx;
    logic [BW-1:0]  baud;
    logic [7:0]     cur_char;
    logic [2:0]     last_char;
    logic           full_now;
    logic           pop;
    logic           push;
    logic           ovf_flag;

    assign full_now  = (count == FULL_COUNT);
    assign pop       = (state == IDLE) && (count != '0);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push      = output_enable && (!full_now || pop);
    assign fifo_full = full_now;
    assign busy      = (state != IDLE) || (count != '0);

`ifdef OUTPUT_HEX_UART_OVERFLOW_COUNT_EN
    assign ovf_flag = (overflow_count != 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_count <= 8'd0;
        end else if (output_enable && !push && overflow_count != 8'hff) begin
            overflow_count <= overflow_count + 8'd1;
        end
    end
`else
    assign ovf_flag = 1'b0;
`endif

    assign last_char = ovf_flag ? 3'd5 : 3'd4;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    always_comb begin
        cur_char = 8'h0a;
        case (char_idx)
            3'd0:    cur_char = hex_ascii(hold[15:12]);
            3'd1:    cur_char = hex_ascii(hold[11:8]);
            3'd2:    cur_char = hex_ascii(hold[7:4]);
            3'd3:    cur_char = hex_ascii(hold[3:0]);
            3'd4:    cur_char = ovf_flag ? 8'h21 : 8'h0a;
            default: cur_char = 8'h0a;
        endcase
    end

    // Storage has no reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= output_data_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hold     <= 16'h0000;
            char_idx <= 3'd0;
            bit_idx  <= 3'd0;
            baud     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;

            case (state)
                IDLE: begin
                    baud    <= '0;
                    uart_tx <= 1'b1;
                    if (pop) begin
                        hold     <= mem[rd_ptr];
                        char_idx <= 3'd0;
                        uart_tx  <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud == BAUD_LAST) begin
                        baud    <= '0;
                        bit_idx <= 3'd0;
                        uart_tx <= cur_char[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= cur_char[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (char_idx < last_char) begin
                            char_idx <= char_idx + 3'd1;
                            uart_tx  <= 1'b0;
                            state    <= START;
                        end else begin
                            uart_tx <= 1'b1;
                            state   <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
